// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU in the EXE stage
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  cpu_clk_50M,
    input  logic                  cpu_rst_n,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic                  annul_i,
    input  logic [DATA_W-1:0]     dividend_i,
    input  logic [DATA_W-1:0]     divisor_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    counter;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   dvd;
    logic [DATA_W-1:0]   dvs;
    logic                neg_q;
    logic                neg_r;

    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;
    logic [DATA_W:0]     partial;
    logic [DATA_W:0]     diff;
    logic                qbit;
    logic [DATA_W-1:0]   rem_next;
    logic [DATA_W-1:0]   quo_next;
    logic [DATA_W-1:0]   q_final;
    logic [DATA_W-1:0]   r_final;

    assign a_neg = signed_i & dividend_i[DATA_W-1];
    assign b_neg = signed_i & divisor_i[DATA_W-1];
    assign abs_a = a_neg ? (~dividend_i + 1'b1) : dividend_i;
    assign abs_b = b_neg ? (~divisor_i + 1'b1) : divisor_i;

    // dvd shifts out dividend bits at the top while quotient bits fill in at the bottom
    assign partial  = {rem, dvd[DATA_W-1]};
    assign diff     = partial - {1'b0, dvs};
    assign qbit     = ~diff[DATA_W];
    assign rem_next = qbit ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
    assign quo_next = {dvd[DATA_W-2:0], qbit};
    assign q_final  = neg_q ? (~quo_next + 1'b1) : quo_next;
    assign r_final  = neg_r ? (~rem_next + 1'b1) : rem_next;

    assign stallreq_o = cpu_rst_n & start_i & ~annul_i & ~ready_o;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state    <= IDLE;
            counter  <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && !annul_i) begin
                        if (divisor_i != '0) begin
                            rem     <= '0;
                            dvd     <= abs_a;
                            dvs     <= abs_b;
                            neg_q   <= a_neg ^ b_neg;
                            neg_r   <= a_neg;
                            counter <= '0;
                            state   <= BUSY;
                        end else begin
                            result_o <= {dividend_i, {DATA_W{1'b1}}};
                            ready_o  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        rem     <= rem_next;
                        dvd     <= quo_next;
                        counter <= counter + 1'b1;
                        if (counter == LAST_CNT) begin
                            result_o <= {r_final, q_final};
                            ready_o  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                // a start still high here belongs to the instruction just finishing
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
